// File: rtl/key_cmd_sequencer.sv
// Key-strobe to expression-buffer command sequencer: edge capture, fixed-priority issue,
// handshake hold, post-command gap and evaluator wait. Optional auto-repeat: KEY_SEQ_AUTOREPEAT_EN.
module key_cmd_sequencer #(
    parameter int WIDTH        = 8,
    parameter int GAP_CYCLES   = 2,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_key_insert,
    input  logic             i_key_del,
    input  logic             i_key_left,
    input  logic             i_key_right,
    input  logic             i_key_eval,
    input  logic [WIDTH-1:0] i_key_data,
    input  logic             i_cmd_ready,
    input  logic             i_eval_done,
    output logic             o_cmd_valid,
    output logic [2:0]       o_cmd_op,
    output logic [WIDTH-1:0] o_cmd_data,
    output logic             o_busy,
    output logic             o_dropped
);

    localparam int GapEff = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GapW   = $clog2(GapEff + 1);

    localparam logic [2:0] OpNop    = 3'd0;
    localparam logic [2:0] OpInsert = 3'd1;
    localparam logic [2:0] OpDel    = 3'd2;
    localparam logic [2:0] OpLeft   = 3'd3;
    localparam logic [2:0] OpRight  = 3'd4;
    localparam logic [2:0] OpEval   = 3'd5;

    localparam int KIns   = 0;
    localparam int KDel   = 1;
    localparam int KLeft  = 2;
    localparam int KRight = 3;
    localparam int KEval  = 4;

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StWaitEval} state_t;

    state_t           r_state, w_state_nxt;
    logic [4:0]       w_keys, w_rise, w_clr, w_drop, w_rep, w_pend_nxt;
    logic [4:0]       r_prev, r_pend;
    logic [WIDTH-1:0] r_latch, r_cmd_data, w_cmd_data_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [GapW-1:0]  r_gap_cnt;
    logic             r_dropped;
    logic             w_valid;

    assign w_keys = {i_key_eval, i_key_right, i_key_left, i_key_del, i_key_insert};
    assign w_rise = w_keys & ~r_prev;
    // An edge landing on a bit cleared this cycle re-arms it rather than being lost.
    assign w_drop     = w_rise & r_pend & ~w_clr;
    assign w_pend_nxt = (r_pend & ~w_clr) | w_rise | w_rep;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr          = '0;
        w_op_nxt       = r_op;
        w_cmd_data_nxt = r_cmd_data;
        unique case (r_state)
            StIdle: begin
                if (|r_pend) begin
                    w_state_nxt    = StIssue;
                    w_cmd_data_nxt = '0;
                    if (r_pend[KEval]) begin
                        w_op_nxt     = OpEval;
                        w_clr[KEval] = 1'b1;
                    end else if (r_pend[KDel]) begin
                        w_op_nxt    = OpDel;
                        w_clr[KDel] = 1'b1;
                    end else if (r_pend[KLeft]) begin
                        w_op_nxt     = OpLeft;
                        w_clr[KLeft] = 1'b1;
                    end else if (r_pend[KRight]) begin
                        w_op_nxt      = OpRight;
                        w_clr[KRight] = 1'b1;
                    end else begin
                        w_op_nxt       = OpInsert;
                        w_clr[KIns]    = 1'b1;
                        w_cmd_data_nxt = r_latch;
                    end
                end
            end
            StIssue: begin
                if (i_cmd_ready) begin
                    w_state_nxt = (r_op == OpEval) ? StWaitEval : StGap;
                end
            end
            StGap: begin
                if (r_gap_cnt == GapW'(GapEff - 1)) begin
                    w_state_nxt = StIdle;
                end
            end
            StWaitEval: begin
                if (i_eval_done) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Previous samples reset high so keys held through reset stay silent until re-pressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev     <= '1;
            r_pend     <= '0;
            r_latch    <= '0;
            r_op       <= OpNop;
            r_cmd_data <= '0;
            r_gap_cnt  <= '0;
            r_dropped  <= 1'b0;
        end else begin
            r_prev     <= w_keys;
            r_pend     <= w_pend_nxt;
            if (w_rise[KIns] && !w_drop[KIns]) begin
                r_latch <= i_key_data;
            end
            r_op       <= w_op_nxt;
            r_cmd_data <= w_cmd_data_nxt;
            r_gap_cnt  <= (r_state == StGap) ? r_gap_cnt + GapW'(1) : '0;
            r_dropped  <= |w_drop;
        end
    end

`ifdef KEY_SEQ_AUTOREPEAT_EN
    localparam int RepDelay = (REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY;
    localparam int RepRate  = (REPEAT_RATE < 1) ? 1 : REPEAT_RATE;
    localparam int RepW     = $clog2(((RepDelay > RepRate) ? RepDelay : RepRate) + 1);

    // Index k covers DEL, LEFT, RIGHT (key bits k+1).
    logic [RepW-1:0] r_rep_cnt [3];
    logic [2:0]      r_rep_arm;
    logic [2:0]      r_rep_fast;

    always_comb begin
        w_rep = '0;
        for (int k = 0; k < 3; k++) begin
            w_rep[k+1] = r_rep_arm[k] & w_keys[k+1] &
                         (r_rep_cnt[k] == (r_rep_fast[k] ? RepW'(RepRate - 1)
                                                         : RepW'(RepDelay - 1)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                r_rep_cnt[k] <= '0;
            end
            r_rep_arm  <= '0;
            r_rep_fast <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!w_keys[k+1]) begin
                    r_rep_cnt[k]  <= '0;
                    r_rep_arm[k]  <= 1'b0;
                    r_rep_fast[k] <= 1'b0;
                end else if (w_rise[k+1]) begin
                    r_rep_cnt[k]  <= '0;
                    r_rep_arm[k]  <= 1'b1;
                    r_rep_fast[k] <= 1'b0;
                end else if (r_rep_arm[k]) begin
                    if (w_rep[k+1]) begin
                        r_rep_cnt[k]  <= '0;
                        r_rep_fast[k] <= 1'b1;
                    end else begin
                        r_rep_cnt[k] <= r_rep_cnt[k] + RepW'(1);
                    end
                end
            end
        end
    end
`else
    logic w_unused_rep_params;
    assign w_unused_rep_params = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
    assign w_rep = '0;
`endif

    assign w_valid     = (r_state == StIssue);
    assign o_cmd_valid = w_valid;
    assign o_cmd_op    = w_valid ? r_op : OpNop;
    assign o_cmd_data  = w_valid ? r_cmd_data : '0;
    assign o_busy      = (r_state != StIdle);
    assign o_dropped   = r_dropped;

endmodule

// File: doc/key_cmd_sequencer.md
KEY_CMD_SEQUENCER -- requirements
Module: key_cmd_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, key code width.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles forced after each non-eval command (values below 1 treated as 1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 16, held-key cycles before first auto-repeat.
REQ-004 SHALL have parameter REPEAT_RATE, default 4, cycles between subsequent auto-repeats.
REQ-005 SHALL have port: clock  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: key_insert, key_del, key_left, key_right, key_eval  in  1 each  level-held key strobes from keyboard encoder.
REQ-008 SHALL have port: key_data  in  WIDTH  key code, valid while key_insert high.
REQ-009 SHALL have port: cmd_ready  in  1  expression buffer accepts command.
REQ-010 SHALL have port: eval_done  in  1  evaluator finished, single-cycle pulse.
REQ-011 SHALL have ports: cmd_valid  out  1; cmd_op  out  3; cmd_data  out  WIDTH  command to expression buffer.
REQ-012 SHALL have ports: busy  out  1  high when state != IDLE; dropped  out  1  one-cycle pulse on lost key event.

Function
REQ-013 SHALL detect rising edges per key (level 1, previous sample 0); each edge sets that key's pending bit.
REQ-014 SHALL capture key_data into a data latch on the key_insert rising edge.
REQ-015 SHALL pulse dropped and leave pending bit/latch unchanged when an edge hits an already-set pending bit.
REQ-016 SHALL encode cmd_op: 0 NOP, 1 INSERT, 2 DEL, 3 LEFT, 4 RIGHT, 5 EVAL; 6-7 never driven.
REQ-017 SHALL select among pending bits with fixed priority EVAL > DEL > LEFT > RIGHT > INSERT.
REQ-018 SHALL implement FSM states IDLE, ISSUE, GAP, WAIT_EVAL.
REQ-019 IDLE: any pending -> ISSUE; selected pending bit cleared; cmd_valid high on next cycle; latency from first sampled-high key level to cmd_valid = 2 cycles.
REQ-020 ISSUE: cmd_valid, cmd_op, cmd_data held stable until cmd_valid && cmd_ready; then EVAL -> WAIT_EVAL, else -> GAP.
REQ-021 cmd_data SHALL equal the data latch for INSERT and 0 for all other ops.
REQ-022 GAP: count GAP_CYCLES cycles, then IDLE; cmd_valid low.
REQ-023 WAIT_EVAL: cmd_valid low until eval_done, then IDLE; eval_done outside WAIT_EVAL ignored.
REQ-024 Edges SHALL be recorded in every state; an edge in the same cycle its bit is cleared SHALL leave the bit set (set wins).
REQ-025 cmd_valid SHALL never drop before handshake, including when higher-priority keys arrive.

Reset
REQ-026 On reset: state IDLE, pending bits 0, data latch 0, counters 0, cmd_valid 0, cmd_op 0, cmd_data 0, busy 0, dropped 0.
REQ-027 Previous-sample registers SHALL reset to 1, so keys held through reset generate no command until released and re-pressed.
REQ-028 Reset mid-ISSUE or mid-WAIT_EVAL SHALL abort immediately; no command reissued after reset.

Configuration
REQ-029 Macro KEY_SEQ_AUTOREPEAT_EN defined: DEL, LEFT, RIGHT held continuously REPEAT_DELAY cycles after edge set pending again, then every REPEAT_RATE cycles while held; counter clears on release; repeats into a set pending bit are silently discarded (no dropped pulse).
REQ-030 Macro undefined: no repeat counters synthesized; held keys produce exactly one command.

Verification
REQ-031 key_insert high 3 cycles, key_data=0x07, cmd_ready=1 -> one INSERT, cmd_data=0x07, cmd_valid 2 cycles after first high sample, 1 cycle wide.
REQ-032 key_del and key_insert (0x0A) rise same cycle, cmd_ready=1 -> DEL issued, then INSERT 0x0A after GAP_CYCLES.
REQ-033 cmd_ready=0 for 5 cycles during ISSUE with key_eval edge arriving -> cmd_op stays INSERT, stable; EVAL issued next.
REQ-034 EVAL handshake, key_left edge during WAIT_EVAL, eval_done after 10 cycles -> busy high throughout, LEFT issued after eval_done.
REQ-035 key_right held 40 cycles, defaults, macro defined -> RIGHT commands at edge, +16, then every 4 while held; macro undefined -> exactly one.
REQ-036 Reset asserted during ISSUE with key_del held -> cmd_valid 0 after reset edge; no DEL until key_del released and re-pressed.
